br_credit_receiver: RTL

//  Receiver end of the credit/valid link whose transmit end is br_credit_sender.
//  - Holds a credit counter for downstream buffer space and returns credits upstream (push_credit).
//  - Forwards received valid/data per flow to a local buffer (pop side).
//  - Runs the sender/receiver reset handshake.

---
 rtl/br_credit_receiver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/br_credit_receiver.sv
// br_credit_receiver: receiver end of a credit/valid link.
// Tracks downstream buffer credits, returns them upstream, forwards per-flow
// valid/data straight through, and runs the sender/receiver reset handshake.
// Optional feature macro: BR_CREDIT_RECEIVER_STALL_EN (push_credit_stall honoured).
module br_credit_receiver #(
  parameter int unsigned NumFlows            = 1,
  parameter int unsigned Width               = 1,
  parameter int unsigned MaxCredit           = 1,
  parameter int unsigned PushCreditMaxChange = 1,
  parameter int unsigned PopCreditMaxChange  = 1,
  parameter bit          RegisterPushOutputs = 1'b0,
  localparam int unsigned CounterWidth    = $clog2(MaxCredit + 1),
  localparam int unsigned PushCreditWidth = $clog2(PushCreditMaxChange + 1),
  localparam int unsigned PopCreditWidth  = $clog2(PopCreditMaxChange + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_sender_in_reset,
  output logic                               push_receiver_in_reset,
  input  logic                               push_credit_stall,
  output logic [PushCreditWidth-1:0]         push_credit,
  input  logic [NumFlows-1:0]                push_valid,
  input  logic [NumFlows-1:0][Width-1:0]     push_data,
  input  logic [PopCreditWidth-1:0]          pop_credit,
  output logic [NumFlows-1:0]                pop_valid,
  output logic [NumFlows-1:0][Width-1:0]     pop_data,
  input  logic [CounterWidth-1:0]            credit_initial,
  input  logic [CounterWidth-1:0]            credit_withhold,
  output logic [CounterWidth-1:0]            credit_count,
  output logic [CounterWidth-1:0]            credit_available
);

  // One extra bit so count + pop_credit never wraps before saturation.
  localparam int unsigned SumWidth = CounterWidth + 1;

  logic [CounterWidth-1:0]    count_q, count_d;
  logic [CounterWidth-1:0]    outstanding_q, outstanding_d;
  logic                       in_reset_q;
  logic [SumWidth-1:0]        sum;
  logic [SumWidth-1:0]        avail;
  logic [PushCreditWidth-1:0] rel;
  logic [CounterWidth-1:0]    valid_cnt;
  logic                       stall_gate;
  logic                       hold_reset;

`ifdef BR_CREDIT_RECEIVER_STALL_EN
  assign stall_gate = push_credit_stall;
`else
  // Stall port kept for interface compatibility but has no effect.
  assign stall_gate = 1'b0;
  logic unused_stall;
  assign unused_stall = push_credit_stall;
`endif

  // Counter and outstanding are held at their reload values while either side is in reset.
  assign hold_reset = in_reset_q | push_sender_in_reset;

  // Forwarding path: zero latency, not gated by credits, muted while sender resets.
  assign pop_valid = push_sender_in_reset ? '0 : push_valid;
  assign pop_data  = push_data;

  // Available credits, release amount and next-state values.
  always_comb begin
    sum           = SumWidth'(count_q) + SumWidth'(pop_credit);
    avail         = '0;
    rel           = '0;
    valid_cnt     = CounterWidth'($countones(push_valid));
    count_d       = count_q;
    outstanding_d = outstanding_q;

    if (sum > SumWidth'(credit_withhold)) begin
      avail = sum - SumWidth'(credit_withhold);
    end

    if (!hold_reset && !stall_gate) begin
      if (avail > SumWidth'(PushCreditMaxChange)) begin
        rel = PushCreditWidth'(PushCreditMaxChange);
      end else begin
        rel = PushCreditWidth'(avail);
      end
    end

    if (hold_reset) begin
      count_d       = credit_initial;
      outstanding_d = '0;
    end else begin
      count_d       = CounterWidth'(sum - SumWidth'(rel));
      outstanding_d = CounterWidth'(SumWidth'(outstanding_q) + SumWidth'(rel)
                                    - SumWidth'(valid_cnt));
    end
  end

  assign credit_count     = count_q;
  assign credit_available = CounterWidth'(avail);

  // Credit counter, outstanding tracker and receiver-in-reset flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= credit_initial;
      outstanding_q <= '0;
      in_reset_q    <= 1'b1;
    end else begin
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      in_reset_q    <= 1'b0;
    end
  end

  generate
    if (RegisterPushOutputs) begin : g_push_reg
      logic [PushCreditWidth-1:0] push_credit_q;
      logic                       push_in_reset_q;

      // Upstream-facing outputs through one flop stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          push_credit_q   <= '0;
          push_in_reset_q <= 1'b1;
        end else begin
          push_credit_q   <= rel;
          push_in_reset_q <= in_reset_q;
        end
      end

      assign push_credit            = push_credit_q;
      assign push_receiver_in_reset = push_in_reset_q;
    end else begin : g_push_comb
      assign push_credit            = rel;
      assign push_receiver_in_reset = in_reset_q;
    end
  endgenerate

`ifndef SYNTHESIS
  // Protocol and configuration checks; the counters never wrap silently.
  a_count_overflow: assert property (@(posedge clk) disable iff (rst)
    (SumWidth'(count_q) + SumWidth'(pop_credit)) <= SumWidth'(MaxCredit));
  a_valid_without_credit: assert property (@(posedge clk) disable iff (rst)
    hold_reset || (valid_cnt <= outstanding_q));
  a_initial_range: assert property (@(posedge clk) disable iff (rst)
    SumWidth'(credit_initial) <= SumWidth'(MaxCredit));
  a_withhold_range: assert property (@(posedge clk) disable iff (rst)
    SumWidth'(credit_withhold) <= SumWidth'(MaxCredit));
`endif

endmodule
